// File: rtl/fsm_count_decoder.sv
// fsm_count_decoder: recovers data bits from a 0-1-2-(3) counter stream, tracks lock, packs words
// Ports:
//   clk, rstn (async, active-low)   clock and reset
//   count_in [1:0]                   observed counter state, sampled every rising edge
//   clr                              synchronous clear of err_count
//   bit_valid / bit_out              strobe + recovered bit (emitted only while locked)
//   word_valid / word_out            strobe + completed word, first bit in MSB
//   locked                           decoder is in LOCKED
//   err_pulse / err_count            strobe per illegal transition + saturating count
module fsm_count_decoder #(
  parameter int WORD_W    = 8,
  parameter int LOCK_CNT  = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [1:0]           count_in,
  input  logic                 clr,
  output logic                 bit_valid,
  output logic                 bit_out,
  output logic                 word_valid,
  output logic [WORD_W-1:0]    word_out,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int IW = $clog2(WORD_W);
  localparam int GW = $clog2(LOCK_CNT + 1);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t              state;
  logic [1:0]          prev;
  logic                prev_v;
  logic [GW-1:0]       good_cnt;
  logic [IW-1:0]       idx;
  logic [WORD_W-2:0]   shreg;
  logic                legal, rec, ill, b;
  logic [WORD_W-1:0]   nxt_word;
  // 3->0 is covered by the mod-4 increment; 2->0 is the only backward step allowed
  always_comb begin
    legal    = (count_in == prev + 2'd1) || (prev == 2'd2 && count_in == 2'd0);
    rec      = prev_v && legal && prev == 2'd2;
    ill      = prev_v && !legal;
    b        = count_in == 2'd3;
    nxt_word = {shreg, b};
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= HUNT;
      prev       <= 2'd0;
      prev_v     <= 1'b0;
      good_cnt   <= '0;
      idx        <= '0;
      shreg      <= '0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
      word_valid <= 1'b0;
      word_out   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      prev       <= count_in;
      prev_v     <= 1'b1;
      bit_valid  <= 1'b0;
      word_valid <= 1'b0;
      err_pulse  <= ill;
      err_count  <= clr ? '0 : (ill && !(&err_count)) ? err_count + 1'b1 : err_count;
      if (ill) begin
        state    <= HUNT;
        locked   <= 1'b0;
        good_cnt <= '0;
        idx      <= '0;
      end else if (rec) begin
        if (state == LOCKED) begin
          bit_valid <= 1'b1;
          bit_out   <= b;
          shreg     <= nxt_word[WORD_W-2:0];
          if (idx == IW'(WORD_W - 1)) begin
            word_out   <= nxt_word;
            word_valid <= 1'b1;
            idx        <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end else if (good_cnt + 1'b1 == GW'(LOCK_CNT)) begin
          state    <= LOCKED;
          locked   <= 1'b1;
          good_cnt <= good_cnt + 1'b1;
        end else begin
          state    <= CHECK;
          good_cnt <= good_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/fsm_count_decoder.md
# fsm_count_decoder

Receive-side decoder for the 2-bit state-count stream produced by the team's input-gated FSM counter. That counter runs 0→1→2 and, in state 2, goes to 3 when its `in` is 1 or back to 0 when `in` is 0. This block watches the `count` stream and works out each `in` bit from the transition that leaves state 2. It flags illegal transitions, acquires and loses lock, and packs the recovered bits into words.

## Interface
- `WORD_W`, default 8: bits per assembled word, ≥2.
- `LOCK_CNT`, default 4: consecutive error-free recovered bits needed to lock, ≥1.
- `ERR_CNT_W`, default 8: width of the error counter.
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `count_in`, in, 2: observed counter state, sampled every `clk` rising edge.
- `clr`, in, 1: synchronous clear of `err_count`.
- `bit_valid`, out, 1: one-cycle strobe, recovered bit on `bit_out`.
- `bit_out`, out, 1: recovered bit.
- `word_valid`, out, 1: one-cycle strobe, `word_out` complete.
- `word_out`, out, WORD_W: assembled word, first bit in MSB.
- `locked`, out, 1: decoder in LOCKED state.
- `err_pulse`, out, 1: one-cycle strobe per illegal transition.
- `err_count`, out, ERR_CNT_W: saturating illegal-transition count.

## Operation
- The block keeps `prev` (last sampled `count_in`) and `prev_v`. Reset clears `prev_v`. The first sample after reset only loads `prev`; no check is made on it.
- Each edge with `prev_v`=1, the pair (`prev`, `count_in`) is evaluated:
  - The legal transitions are 0→1, 1→2, 2→3, 3→0 and 2→0.
  - 2→3 recovers bit 1.
  - 2→0 recovers bit 0.
  - Every other pair is illegal, including holds such as 2→2.
- `prev` updates every edge, whether the pair was legal or illegal.
- Lock FSM has three states: HUNT, CHECK, LOCKED. The recovered-bit count is `good_cnt`.
  - HUNT: a recovered bit sets `good_cnt`=1 and moves to CHECK. If LOCK_CNT=1 it goes straight to LOCKED.
  - CHECK: each recovered bit increments `good_cnt`. The bit that makes `good_cnt`=LOCK_CNT moves to LOCKED. An illegal pair moves to HUNT and clears `good_cnt`.
  - LOCKED: an illegal pair moves to HUNT and clears `good_cnt`.
  - Bits recovered in HUNT or CHECK, including the bit that triggers lock, are not emitted.
- Bit emission and word assembly:
  - Only bits recovered while the FSM is already in LOCKED are emitted on `bit_valid`/`bit_out`.
  - Each emitted bit shifts into the word register MSB-first and increments a bit index.
  - On the WORD_W-th bit, `word_out` loads the full word, `word_valid` pulses and the index wraps to 0.
  - Leaving LOCKED discards the partial word and zeroes the index. `word_out` keeps its last complete value.
- Error handling:
  - Every illegal pair pulses `err_pulse` and increments `err_count`, in any FSM state.
  - `err_count` saturates at all-ones.
  - `clr` sets `err_count` to 0 and takes priority over a same-edge increment.

## Timing
- Reset values: all outputs 0, FSM=HUNT, `good_cnt`=0, bit index 0, `prev_v`=0. Reset is honoured mid-word and mid-lock.
- All outputs are registered.
- The pair (`prev`, `count_in`) is decoded combinationally. Results are registered on the edge that samples `count_in`, so latency is 1 cycle from `count_in` to `bit_valid`, `err_pulse` and FSM update.
- `word_valid` asserts on the same cycle as the final bit's `bit_valid`.
- `locked` rises on the cycle after the edge that samples the LOCK_CNT-th recovered bit's terminating value.
- `locked` falls together with the `err_pulse` that caused the loss.
- The minimum spacing between recovered bits is 3 cycles; frames are 0,1,2 for bit 0 and 0,1,2,3 for bit 1.
- Word completion and lock loss cannot coincide, because one pair is either legal or illegal.

## Test plan
- Hold `rstn`=0 with `count_in` toggling → all outputs 0. Release, then feed 0,1,2,0 ×4 (LOCK_CNT=4) → `locked`=1 after the 4th 2→0, no `bit_valid`, `err_count`=0.
- Locked, feed frames for bits 1,0,1,0,0,1,0,1 → 8 `bit_valid` strobes with matching `bit_out`; one `word_valid` with `word_out`=8'hA5 on the 8th strobe.
- Locked with 3 bits into a word, inject 1→3 → `err_pulse`, `err_count`=1, `locked`=0 on the same cycle. Relock takes 4 frames, then the next 8 bits give one word with no leftover bits.
- Feed 0,1,2,2,0 → 2→2 illegal, `err_count`+1. The following 2→0 is legal but only starts CHECK from HUNT, with `good_cnt`=1.
- ERR_CNT_W=2: 5 illegal pairs → `err_count`=3 (saturated). Assert `clr` on the same edge as a 6th error → `err_count`=0 and `err_pulse`=1.
- Locked, 5 bits into a word, assert `rstn`=0 asynchronously mid-cycle → outputs 0 immediately. After release, the first sample raises no error and lock must be re-acquired.
